// File: rtl/dfc_pkg.sv
// Shared DFC link helpers: tag-width math and channel limits, used by sender and receiver/demux.
package dfc_pkg;

    localparam int DFC_MAX_CHANNELS = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A single-channel link still carries a 1-bit tag so the field never collapses to zero width.
    function automatic int chan_tag_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/dfc_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester after the last granted index.
// Latency: combinational grant; pointer advances on the clk after an accepted grant.
// Backpressure: pointer holds unless advance is asserted, so idle cycles do not shift priority.
module dfc_rr_arb
    import dfc_pkg::*;
#(
    parameter int channels = 4,
    parameter int cw       = chan_tag_w(channels)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [channels-1:0] req,
    input  logic                advance,
    output logic [channels-1:0] grant,
    output logic [cw-1:0]       grant_idx
);

    logic [cw-1:0] last;

    always_comb begin
        logic found;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 1; k <= channels; k++) begin
            int idx;
            idx = (int'(last) + k) % channels;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = cw'(idx);
            end
        end
    end

    // Reset to the top index so channel 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= cw'(channels - 1);
        end else if (advance && (|grant)) begin
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/dfc_mux_sender.sv
// Multi-channel srdy/drdy to DFC link sender with round-robin channel arbitration (DFC_FC_REG_EN registers p_fc_n).
// Latency: 1 cycle from c_srdy&c_drdy transfer to registered p_vld/p_chan/p_data.
// Backpressure: per-channel p_fc_n gates eligibility; c_drdy is the one-hot grant, zero in reset or when nothing is eligible.
module dfc_mux_sender
    import dfc_pkg::*;
#(
    parameter int width    = 8,
    parameter int channels = 4,
    parameter int cw       = chan_tag_w(channels)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [channels-1:0]       c_srdy,
    output logic [channels-1:0]       c_drdy,
    input  logic [channels*width-1:0] c_data,
    output logic                      p_vld,
    output logic [cw-1:0]             p_chan,
    output logic [width-1:0]          p_data,
    input  logic [channels-1:0]       p_fc_n
);

    logic [channels-1:0] fc;
    logic [channels-1:0] elig;
    logic [channels-1:0] grant;
    logic [cw-1:0]       grant_idx;
    logic                xfer;

`ifdef DFC_FC_REG_EN
    // Starts all-stopped: nothing is granted until the far end's fc has been sampled once.
    logic [channels-1:0] fc_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            fc_q <= '0;
        end else begin
            fc_q <= p_fc_n;
        end
    end
    assign fc = fc_q;
`else
    assign fc = p_fc_n;
`endif

    assign elig   = c_srdy & fc & {channels{!reset}};
    assign c_drdy = grant;
    assign xfer   = |(c_srdy & grant);

    dfc_rr_arb #(
        .channels (channels),
        .cw       (cw)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (elig),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Tag and data hold their last launched values while the link idles.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_vld  <= 1'b0;
            p_chan <= '0;
            p_data <= '0;
        end else begin
            p_vld <= xfer;
            if (xfer) begin
                p_chan <= grant_idx;
                p_data <= c_data[int'(grant_idx)*width +: width];
            end
        end
    end

endmodule

// File: tb/tb_dfc_mux_sender.sv
// Table-driven check of dfc_mux_sender (4 channels, 8-bit data) with a launch scoreboard.
module tb_dfc_mux_sender;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 2;

    logic           clk;
    logic           reset;
    logic [N-1:0]   c_srdy;
    logic [N-1:0]   c_drdy;
    logic [N*W-1:0] c_data;
    logic           p_vld;
    logic [CW-1:0]  p_chan;
    logic [W-1:0]   p_data;
    logic [N-1:0]   p_fc_n;

    dfc_mux_sender #(
        .width    (W),
        .channels (N),
        .cw       (CW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .c_srdy (c_srdy),
        .c_drdy (c_drdy),
        .c_data (c_data),
        .p_vld  (p_vld),
        .p_chan (p_chan),
        .p_data (p_data),
        .p_fc_n (p_fc_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [N-1:0] srdy;
        logic [N-1:0] fc;
        logic [N-1:0] exp_drdy;
    } vec_t;

    typedef struct {
        logic [CW-1:0] chan;
        logic [W-1:0]  data;
    } launch_t;

    vec_t    tbl[$];
    launch_t sb[$];
    int      total;
    int      passed;

    task automatic add(input logic rst, input logic [N-1:0] srdy, input logic [N-1:0] fc,
                       input logic [N-1:0] exp_drdy, input int reps);
        vec_t v;
        v.rst = rst; v.srdy = srdy; v.fc = fc; v.exp_drdy = exp_drdy;
        for (int r = 0; r < reps; r++) tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int e, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s entry %0d: got %0h expected %0h", name, e, act, exp);
        end
    endtask

    initial begin
        launch_t       exp_l;
        logic [CW-1:0] last_chan;
        logic [W-1:0]  last_data;
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        c_srdy = '0;
        c_data = '0;
        p_fc_n = '0;
        last_chan = '0;
        last_data = '0;

`ifdef DFC_FC_REG_EN
        add(1, 4'hF, 4'hF, 4'h0, 2);
        add(0, 4'h1, 4'hF, 4'h0, 1);   // fc register still all-stopped
        add(0, 4'h1, 4'hF, 4'h1, 2);
        add(0, 4'h1, 4'hE, 4'h1, 1);   // drop on ch0 takes effect a cycle late
        add(0, 4'h1, 4'hE, 4'h0, 2);
        add(0, 4'h1, 4'hF, 4'h0, 1);
        add(0, 4'h1, 4'hF, 4'h1, 1);
`else
        add(1, 4'hF, 4'hF, 4'h0, 2);   // reset masks c_drdy regardless of inputs
        add(0, 4'h4, 4'hF, 4'h4, 4);   // lone ch2, back-to-back
        add(1, 4'hF, 4'hF, 4'h0, 1);
        add(0, 4'hF, 4'hF, 4'h1, 1); add(0, 4'hF, 4'hF, 4'h2, 1);
        add(0, 4'hF, 4'hF, 4'h4, 1); add(0, 4'hF, 4'hF, 4'h8, 1);
        add(0, 4'hF, 4'hF, 4'h1, 1); add(0, 4'hF, 4'hF, 4'h2, 1);
        add(0, 4'hF, 4'hF, 4'h4, 1); add(0, 4'hF, 4'hF, 4'h8, 1);
        for (int r = 0; r < 2; r++) begin   // ch2 stopped: rotation skips it
            add(0, 4'hF, 4'hB, 4'h1, 1); add(0, 4'hF, 4'hB, 4'h2, 1); add(0, 4'hF, 4'hB, 4'h8, 1);
        end
        add(0, 4'h0, 4'hF, 4'h0, 1);   // idle: pointer holds, outputs hold
        add(0, 4'hF, 4'hF, 4'h1, 1);
        add(0, 4'hA, 4'hF, 4'h2, 1);
        add(0, 4'h9, 4'hF, 4'h8, 1);
        add(0, 4'h9, 4'h8, 4'h8, 1);
        add(0, 4'h1, 4'h0, 4'h0, 1);   // srdy without fc is never granted
        add(0, 4'h2, 4'hF, 4'h2, 4);   // ch1 burst, then its fc drops
        add(0, 4'h2, 4'hD, 4'h0, 2);
        add(0, 4'hF, 4'hF, 4'h4, 1);
        add(0, 4'hF, 4'hF, 4'h8, 1);
        add(1, 4'hF, 4'hF, 4'h0, 1);   // mid-operation reset restarts priority at ch0
        add(0, 4'hF, 4'hF, 4'h1, 1);
`endif

        for (int e = 0; e < tbl.size(); e++) begin
            @(negedge clk);
            reset  = tbl[e].rst;
            c_srdy = tbl[e].srdy;
            p_fc_n = tbl[e].fc;
            for (int i = 0; i < N; i++) c_data[i*W +: W] = W'((e * 16 + 8 * i + 3) & 8'hFF);
            #1;
            chk("c_drdy", e, 32'(c_drdy), 32'(tbl[e].exp_drdy));
            if (!tbl[e].rst && ((tbl[e].exp_drdy & tbl[e].srdy) != '0)) begin
                for (int i = 0; i < N; i++) begin
                    if (tbl[e].exp_drdy[i]) begin
                        exp_l.chan = CW'(i);
                        exp_l.data = W'((e * 16 + 8 * i + 3) & 8'hFF);
                    end
                end
                sb.push_back(exp_l);
            end
            @(posedge clk);
            #1;
            if (tbl[e].rst) begin
                last_chan = '0;
                last_data = '0;
                chk("reset p_vld", e, 32'(p_vld), 32'd0);
                chk("reset p_chan", e, 32'(p_chan), 32'd0);
                chk("reset p_data", e, 32'(p_data), 32'd0);
            end else if (sb.size() > 0) begin
                exp_l = sb.pop_front();
                last_chan = exp_l.chan;
                last_data = exp_l.data;
                chk("launch p_vld", e, 32'(p_vld), 32'd1);
                chk("launch p_chan", e, 32'(p_chan), 32'(exp_l.chan));
                chk("launch p_data", e, 32'(p_data), 32'(exp_l.data));
            end else begin
                chk("idle p_vld", e, 32'(p_vld), 32'd0);
                chk("hold p_chan", e, 32'(p_chan), 32'(last_chan));
                chk("hold p_data", e, 32'(p_data), 32'(last_data));
            end
        end

        chk("scoreboard drained", tbl.size(), 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
